// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the combinational-read instruction memory
// and buffers fetched words in a small in-order prefetch FIFO feeding decode.
module imem_fetch_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [2:0]        fifo_count
);

    localparam int                PTR_W   = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0]        DEPTH_C = 3'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1'b1);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2'b10);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];

    logic pop_s;
    logic space_s;
    logic fetch_s;

    assign imem_addr  = pc_q;
    assign fifo_count = count_q;
    assign out_valid  = (count_q != 3'd0);
    assign pop_s      = out_valid & out_ready;
    // A full FIFO can still accept a push when its head leaves in the same cycle.
    assign space_s    = (count_q < DEPTH_C) | pop_s;
    assign fetch_s    = fetch_en & ~redirect_valid & space_s;

    // Head outputs come straight from storage; empty FIFO shows zeros.
    always_comb begin
        if (out_valid) begin
            out_instr = instr_mem_q[rd_ptr_q];
            out_pc    = pc_mem_q[rd_ptr_q];
        end else begin
            out_instr = '0;
            out_pc    = '0;
        end
    end

    // Next-state for PC, pointers and occupancy; redirect flushes and retargets.
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[ADDR_W-1:1], 1'b0};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 3'd0;
        end else begin
            if (fetch_s) begin
                pc_d     = pc_q + PC_STEP;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                pc_d     = pc_q;
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({fetch_s, pop_s})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 3'd0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage: each entry keeps its fetch address paired with the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (fetch_s) begin
            pc_mem_q[wr_ptr_q]    <= pc_q;
            instr_mem_q[wr_ptr_q] <= imem_instr;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= pc_mem_q[i];
                instr_mem_q[i] <= instr_mem_q[i];
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a queue of expected fetch addresses is
// filled as fetches are expected and drained on each decode handshake.
module tb_imem_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        fetch_en;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_q [$];
    logic [15:0] m_pc;
    bit          m_known = 1'b0;

    imem_fetch_ctrl #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Instruction memory model: word at byte address a is a>>1.
    assign imem_instr = imem_addr >> 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_state();
        if (m_known) begin
            check_eq("imem_addr", imem_addr, m_pc);
            check_eq("fifo_count", fifo_count, exp_q.size());
            check_eq("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check_eq("out_pc", out_pc, exp_q[0]);
                check_eq("out_instr", out_instr, exp_q[0] >> 1);
            end else begin
                check_eq("out_pc_empty", out_pc, 16'h0000);
                check_eq("out_instr_empty", out_instr, 16'h0000);
            end
        end
    endtask

    // Check current outputs, advance the reference for this edge, then clock.
    task automatic tick();
        bit pop;
        bit space;
        check_state();
        if (rst) begin
            exp_q.delete();
            m_pc    = 16'h0000;
            m_known = 1'b1;
        end else if (m_known) begin
            pop   = (exp_q.size() != 0) && out_ready;
            space = (exp_q.size() < DEPTH) || pop;
            if (pop) void'(exp_q.pop_front());
            if (redirect_valid) begin
                exp_q.delete();
                m_pc = {redirect_pc[15:1], 1'b0};
            end else if (fetch_en && space) begin
                exp_q.push_back(m_pc);
                m_pc = m_pc + 16'd2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 16'h0000; out_ready = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset release and back-to-back stream
        ticks(2);
        rst = 1'b0;
        tick();
        check_eq("t1_first_pc", out_pc, 16'h0000);
        check_eq("t1_first_instr", out_instr, 16'h0000);
        tick();
        check_eq("t1_second_pc", out_pc, 16'h0002);
        check_eq("t1_second_instr", out_instr, 16'h0001);
        ticks(4);

        // 2: redirect latency
        redirect_valid = 1'b1; redirect_pc = 16'h0070;
        tick();
        redirect_valid = 1'b0;
        check_eq("t2_flush_valid", out_valid, 1'b0);
        tick();
        check_eq("t2_target_pc", out_pc, 16'h0070);
        check_eq("t2_target_instr", out_instr, 16'h0038);
        tick();
        check_eq("t2_next_pc", out_pc, 16'h0072);

        // 3: odd redirect target is aligned
        redirect_valid = 1'b1; redirect_pc = 16'h0091;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_eq("t3_aligned_pc", out_pc, 16'h0090);
        check_eq("t3_aligned_instr", out_instr, 16'h0048);
        ticks(2);

        // 4: backpressure fills FIFO, then ordered drain
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        ticks(6);
        check_eq("t4_full_count", fifo_count, 3'd2);
        check_eq("t4_frozen_addr", imem_addr, 16'h0004);
        check_eq("t4_head_pc", out_pc, 16'h0000);
        out_ready = 1'b1;
        ticks(4);

        // 5: PC wraps past 0xFFFE
        redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
        tick();
        redirect_valid = 1'b0;
        ticks(3);
        check_eq("t5_wrap_pc", out_pc, 16'h0000);
        ticks(2);

        // 6: halt with entries queued, drain, resume, reset mid-stream, redirect on full+pop
        out_ready = 1'b0;
        ticks(2);
        fetch_en = 1'b0; out_ready = 1'b1;
        ticks(4);
        check_eq("t6_halt_empty", out_valid, 1'b0);
        fetch_en = 1'b1;
        ticks(3);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h1234;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        check_eq("t6_rst_addr", imem_addr, 16'h0000);
        tick();
        out_ready = 1'b0;
        ticks(3);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect_valid = 1'b0;
        check_eq("t6_redir_count", fifo_count, 3'd0);
        ticks(4);

        // Random traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 16'($urandom());
            fetch_en       = ($urandom_range(0, 9) < 8);
            out_ready      = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst = 1'b0; redirect_valid = 1'b0;
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
